// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: register map,
// register field positions, scan FSM states and event packing.
package keypad_pkg;

  // Avalon register addresses
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_CMD     = 2'd3;

  // Event word: {press, code}
  localparam int EV_W           = 9;
  localparam int EV_PRESS_BIT   = 8;
  localparam int EV_CODE_W      = 8;
  localparam int DATA_VALID_BIT = 31;

  // STATUS fields
  localparam int ST_OVF_BIT   = 8;
  localparam int ST_EMPTY_BIT = 9;
  localparam int ST_FULL_BIT  = 10;
  localparam int ST_MAP_LSB   = 16;

  // CONTROL bits
  localparam int CTRL_W      = 3;
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_REL_EN = 2;

  // CMD bits
  localparam int CMD_CLR_OVF = 0;
  localparam int CMD_FLUSH   = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EVAL   = 2'd2,
    NEXT   = 2'd3
  } scan_state_t;

  // Pack a press/release flag and a key code into one FIFO entry.
  function automatic logic [EV_W-1:0] make_event(input logic press,
                                                 input logic [EV_CODE_W-1:0] code);
    logic [EV_W-1:0] ev;
    ev = {EV_W{1'b0}};
    ev[EV_PRESS_BIT] = press;
    ev[EV_CODE_W-1:0] = code;
    return ev;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Synchronous event FIFO. A push into a full FIFO is dropped and flagged on
// the one-cycle overflow output; a simultaneous pop makes room so the push
// is kept. Flush wins over push and pop.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [EV_W-1:0]               din,
  output logic [EV_W-1:0]               dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

  logic [EV_W-1:0] mem_q [FIFO_DEPTH];
  logic [EV_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == DEPTH_N);
  assign empty = (cnt_q == {NW{1'b0}});

  // Decide which requests are honoured this cycle and flag dropped pushes.
  always_comb begin
    pop_ok_s  = pop & ~empty & ~flush;
    push_ok_s = push & ~flush & (~full | pop_ok_s);
    overflow  = push & ~flush & full & ~pop_ok_s;
  end

  // Next pointer, count and storage values.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = {AW{1'b0}};
      rd_d  = {AW{1'b0}};
      cnt_d = {NW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok_s) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      cnt_d = cnt_q + NW'(push_ok_s) - NW'(pop_ok_s);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {EV_W{1'b0}};
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {NW{1'b0}};
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one row low at a time, debounces every key
// through a per-key counter and queues press/release events for the CPU,
// which pops them through an Avalon-MM register window.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [ROWS-1:0]   row_n,
  input  logic [COLS-1:0]   col_n,
  output logic              irq
);

  localparam int KEYS = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int KW   = $clog2(KEYS);
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
  // SETTLE lasts SETTLE_LAST+1 cycles so SETTLE+EVAL+NEXT is SCAN_DIV.
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SCAN_DIV - COLS - 2);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
  localparam logic [3:0]    DB_LAST     = 4'(DEBOUNCE - 1);

  // Synchroniser
  logic [COLS-1:0]   col_meta_q, col_meta_d;
  logic [COLS-1:0]   col_sync_q, col_sync_d;
  // Scan FSM
  scan_state_t       state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic              eval_s;
  // Debounce
  logic [KEYS-1:0]   stable_q, stable_d;
  logic [3:0]        db_cnt_q [KEYS];
  logic [3:0]        db_cnt_d [KEYS];
  logic [KW-1:0]     key_idx_s;
  logic              sample_s;
  logic              push_s;
  logic              ev_press_s;
  // Registers
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              flush_s;
  logic              ovf_clr_s;
  logic              pop_s;
  logic [31:0]       status_s;
  logic [31:0]       data_word_s;
  // FIFO
  logic [EV_W-1:0]   fifo_dout_s;
  logic [FCW-1:0]    fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_ovf_s;
  logic              unused_s;

  assign unused_s = ^writedata[31:CTRL_W];
  assign readdata = readdata_q;
  assign row_n    = row_n_q;
  // Built only from flops so an event pushed in EVAL shows on the next cycle.
  assign irq      = ctrl_q[CTRL_IRQ_EN] & (~fifo_empty_s | ovf_q);

  // Two-stage column synchroniser.
  always_comb begin
    col_meta_d = col_n;
    col_sync_d = col_meta_q;
  end

  // Scan FSM next state: settle, walk the columns, step to the next row.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    settle_d = settle_q;
    if (!ctrl_q[CTRL_ENABLE]) begin
      state_d  = IDLE;
      row_d    = {RW{1'b0}};
      col_d    = {CW{1'b0}};
      settle_d = {SW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          row_d    = {RW{1'b0}};
          settle_d = {SW{1'b0}};
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = EVAL;
            col_d    = {CW{1'b0}};
            settle_d = {SW{1'b0}};
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
        EVAL: begin
          if (col_q == COL_LAST) begin
            state_d = NEXT;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        NEXT: begin
          state_d  = SETTLE;
          settle_d = {SW{1'b0}};
          row_d    = (row_q == ROW_LAST) ? {RW{1'b0}} : row_q + RW'(1);
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Scan FSM outputs: next row drive and the evaluate strobe.
  always_comb begin
    row_n_d = {ROWS{1'b1}};
    case (state_d)
      SETTLE, EVAL, NEXT: row_n_d = ~(ROWS'(1) << row_d);
      IDLE:               row_n_d = {ROWS{1'b1}};
      default:            row_n_d = {ROWS{1'b1}};
    endcase
    eval_s = (state_q == EVAL) & ctrl_q[CTRL_ENABLE];
  end

  // Scan FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= {RW{1'b0}};
      col_q    <= {CW{1'b0}};
      settle_q <= {SW{1'b0}};
      row_n_q  <= {ROWS{1'b1}};
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      row_n_q  <= row_n_d;
    end
  end

  // Per-key debounce on the key under evaluation; a full count toggles it.
  always_comb begin
    key_idx_s  = KW'(int'(row_q) * COLS + int'(col_q));
    sample_s   = ~col_sync_q[col_q];
    stable_d   = stable_q;
    db_cnt_d   = db_cnt_q;
    push_s     = 1'b0;
    ev_press_s = 1'b0;
    if (!ctrl_q[CTRL_ENABLE]) begin
      stable_d = {KEYS{1'b0}};
      for (int k = 0; k < KEYS; k++) db_cnt_d[k] = 4'd0;
    end else if (eval_s) begin
      if (sample_s != stable_q[key_idx_s]) begin
        if (db_cnt_q[key_idx_s] == DB_LAST) begin
          stable_d[key_idx_s] = sample_s;
          db_cnt_d[key_idx_s] = 4'd0;
          push_s              = sample_s | ctrl_q[CTRL_REL_EN];
          ev_press_s          = sample_s;
        end else begin
          db_cnt_d[key_idx_s] = db_cnt_q[key_idx_s] + 4'd1;
        end
      end else begin
        db_cnt_d[key_idx_s] = 4'd0;
      end
    end else begin
      stable_d = stable_q;
    end
  end

  // Register writes, pop strobe and sticky overflow.
  always_comb begin
    ctrl_d    = ctrl_q;
    flush_s   = 1'b0;
    ovf_clr_s = 1'b0;
    if (write) begin
      case (address)
        REG_CONTROL: ctrl_d = writedata[CTRL_W-1:0];
        REG_CMD: begin
          flush_s   = writedata[CMD_FLUSH];
          ovf_clr_s = writedata[CMD_CLR_OVF];
        end
        default: ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
    pop_s = read & (address == REG_DATA);
    if (fifo_ovf_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Read data: assemble STATUS/DATA words and hold readdata between reads.
  always_comb begin
    status_s                 = 32'd0;
    status_s[7:0]            = 8'(fifo_count_s);
    status_s[ST_OVF_BIT]     = ovf_q;
    status_s[ST_EMPTY_BIT]   = fifo_empty_s;
    status_s[ST_FULL_BIT]    = fifo_full_s;
    status_s[31:ST_MAP_LSB]  = 16'(stable_q);
    data_word_s              = 32'd0;
    data_word_s[EV_W-1:0]    = fifo_dout_s;
    data_word_s[DATA_VALID_BIT] = 1'b1;
    readdata_d = readdata_q;
    if (read) begin
      case (address)
        REG_DATA:    readdata_d = fifo_empty_s ? 32'd0 : data_word_s;
        REG_STATUS:  readdata_d = status_s;
        REG_CONTROL: readdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
        REG_CMD:     readdata_d = 32'd0;
        default:     readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  // Datapath registers: synchroniser, debounce state, control and bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_q <= {COLS{1'b1}};
      col_sync_q <= {COLS{1'b1}};
      stable_q   <= {KEYS{1'b0}};
      for (int k = 0; k < KEYS; k++) db_cnt_q[k] <= 4'd0;
      ctrl_q     <= {CTRL_W{1'b0}};
      ovf_q      <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      col_meta_q <= col_meta_d;
      col_sync_q <= col_sync_d;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      readdata_q <= readdata_d;
    end
  end

  keypad_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (flush_s),
    .din      (make_event(ev_press_s, EV_CODE_W'(key_idx_s))),
    .dout     (fifo_dout_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .overflow (fifo_ovf_s)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner. A keypad model pulls columns low for
// pressed keys on the driven row. Key changes are applied at the start of each
// scan (row 0 entering SETTLE), so the reference model works one whole scan at
// a time: per-key counters, stable bitmap and an event queue.
module tb_keypad_scanner;

  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 16, DEBOUNCE = 3, FIFO_DEPTH = 4;
  localparam int KEYS = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        irq;
  logic [15:0] keys = 16'd0;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [15:0] m_stable;
  int          m_cnt [KEYS];
  logic [8:0]  m_q [$];
  logic        m_ovf;
  logic [2:0]  m_ctrl;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .row_n(row_n), .col_n(col_n),
    .irq(irq)
  );

  // keypad: a pressed key shorts its column to its row when the row is low
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void model_clear_keys();
    m_stable = 16'd0;
    for (int k = 0; k < KEYS; k++) m_cnt[k] = 0;
  endfunction

  function automatic void model_reset();
    model_clear_keys();
    m_q.delete();
    m_ovf = 1'b0;
    m_ctrl = 3'd0;
  endfunction

  function automatic void model_push(input logic [8:0] ev);
    if (m_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
    else m_q.push_back(ev);
  endfunction

  // one full scan, keys visited in code order
  function automatic void model_scan();
    for (int k = 0; k < KEYS; k++) begin
      if (keys[k] != m_stable[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == DEBOUNCE) begin
          m_stable[k] = keys[k];
          m_cnt[k] = 0;
          if (keys[k] || m_ctrl[2]) model_push({keys[k], 8'(k)});
        end
      end else begin
        m_cnt[k] = 0;
      end
    end
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'd0;
    s[7:0] = 8'(m_q.size());
    s[8] = m_ovf;
    s[9] = (m_q.size() == 0);
    s[10] = (m_q.size() == FIFO_DEPTH);
    s[31:16] = m_stable;
    return s;
  endfunction

  function automatic logic exp_irq();
    return m_ctrl[1] & ((m_q.size() != 0) | m_ovf);
  endfunction

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  // wait for row 0 to start being driven (start of a scan)
  task automatic wait_row0(output bit ok);
    logic [3:0] prev;
    int n;
    prev = row_n;
    ok = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (row_n == 4'b1110 && prev != 4'b1110) begin
        ok = 1'b1;
        break;
      end
      prev = row_n;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL scan_start: row_n stuck at %b, wanted a transition to 1110", row_n);
    end
  endtask

  // Scan boundary: apply keys, check status/irq, optional pops, CMD and
  // CONTROL writes (all inside row 0 SETTLE), then advance the model one scan.
  task automatic boundary(input int npops, input logic [1:0] cmd,
                          input logic [2:0] ctrl, input logic [15:0] nk);
    bit ok;
    logic [31:0] d;
    logic [31:0] e;
    wait_row0(ok);
    if (!ok) return;
    keys = nk;
    bus_read(2'd1, d);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL status: got %h want %h", d, exp_status());
    end
    total++;
    if (irq !== exp_irq()) begin
      bad++;
      $display("FAIL irq: got %b want %b", irq, exp_irq());
    end
    for (int i = 0; i < npops; i++) begin
      bus_read(2'd0, d);
      if (m_q.size() != 0) e = {1'b1, 22'd0, m_q.pop_front()};
      else e = 32'd0;
      total++;
      if (d !== e) begin
        bad++;
        $display("FAIL data_pop: got %h want %h", d, e);
      end
      total++;
      if (irq !== exp_irq()) begin
        bad++;
        $display("FAIL irq_after_pop: got %b want %b", irq, exp_irq());
      end
    end
    if (cmd != 2'd0) begin
      bus_write(2'd3, {30'd0, cmd});
      if (cmd[1]) m_q.delete();
      if (cmd[0]) m_ovf = 1'b0;
    end
    if (ctrl != m_ctrl) begin
      bus_write(2'd2, {29'd0, ctrl});
      m_ctrl = ctrl;
    end
    model_scan();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (row_n !== 4'b1111) begin bad++; $display("FAIL reset_row_n: got %b want 1111", row_n); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++;
    if (readdata !== 32'd0) begin bad++; $display("FAIL reset_readdata: got %h want 0", readdata); end
    reset = 1'b0;
    model_reset();
    bus_read(2'd1, d);
    total++;
    if (d !== 32'h0000_0200) begin bad++; $display("FAIL reset_status: got %h want 00000200", d); end
    bus_read(2'd2, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_control: got %h want 0", d); end
  endtask

  task automatic test_press();
    bit ok;
    logic [31:0] d;
    bus_write(2'd2, 32'd3);
    m_ctrl = 3'd3;
    repeat (6) boundary(0, 2'd0, 3'd3, 16'h0200);
    wait_row0(ok);
    if (!ok) return;
    bus_read(2'd1, d);
    total++;
    if (d !== 32'h0200_0001) begin bad++; $display("FAIL press_status: got %h want 02000001", d); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL press_irq: got %b want 1", irq); end
    bus_read(2'd0, d);
    total++;
    if (d !== 32'h8000_0109) begin bad++; $display("FAIL press_data: got %h want 80000109", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL press_irq_drop: got %b want 0", irq); end
    void'(m_q.pop_front());
    model_scan();
  endtask

  task automatic test_release();
    repeat (4) boundary(0, 2'd0, 3'd3, 16'h0000);
    repeat (4) boundary(0, 2'd0, 3'd3, 16'h0200);
    boundary(1, 2'd0, 3'd7, 16'h0000);
    repeat (3) boundary(0, 2'd0, 3'd7, 16'h0000);
    boundary(1, 2'd0, 3'd3, 16'h0000);
  endtask

  task automatic test_bounce();
    repeat (4) boundary(0, 2'd0, 3'd3, 16'h0001);
    for (int i = 0; i < 8; i++)
      boundary(0, 2'd0, 3'd3, (i % 2 == 0) ? 16'h0021 : 16'h0001);
    boundary(1, 2'd0, 3'd3, 16'h0001);
  endtask

  task automatic test_overflow();
    logic [15:0] k5;
    k5 = 16'h8449;
    repeat (4) boundary(0, 2'd0, 3'd3, k5);
    boundary(0, 2'd1, 3'd3, k5);
    boundary(0, 2'd2, 3'd3, k5);
    boundary(0, 2'd0, 3'd3, k5);
  endtask

  task automatic test_disable();
    bit ok;
    logic [31:0] d;
    repeat (4) boundary(0, 2'd0, 3'd7, 16'h8448);
    boundary(0, 2'd0, 3'd7, 16'h8448);
    wait_row0(ok);
    if (!ok) return;
    repeat (11) @(negedge clk);
    bus_write(2'd2, 32'd2);
    m_ctrl = 3'd2;
    model_clear_keys();
    @(negedge clk);
    total++;
    if (row_n !== 4'b1111) begin bad++; $display("FAIL disable_row_n: got %b want 1111", row_n); end
    bus_read(2'd1, d);
    total++;
    if (d !== exp_status()) begin bad++; $display("FAIL disable_status: got %h want %h", d, exp_status()); end
    total++;
    if (irq !== exp_irq()) begin bad++; $display("FAIL disable_irq: got %b want %b", irq, exp_irq()); end
    total++;
    if (row_n !== 4'b1111) begin bad++; $display("FAIL disable_idle: got %b want 1111", row_n); end
    bus_write(2'd2, 32'd3);
    m_ctrl = 3'd3;
  endtask

  task automatic test_random();
    logic [15:0] nk;
    logic [1:0]  cmd;
    logic [2:0]  ctrl;
    int          np;
    nk = keys;
    for (int s = 0; s < 30; s++) begin
      for (int k = 0; k < KEYS; k++)
        if ($urandom_range(0, 7) == 0) nk[k] = ~nk[k];
      np = int'($urandom_range(0, 2));
      cmd = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      ctrl = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
      boundary(np, cmd, ctrl, nk);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    logic [31:0] d;
    repeat (4) boundary(0, 2'd0, 3'd3, 16'hFFFF);
    wait_row0(ok);
    repeat ($urandom_range(5, 40)) @(negedge clk);
    bus_read(2'd1, d);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (readdata !== 32'd0) begin bad++; $display("FAIL midreset_readdata: got %h want 0", readdata); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", irq); end
    total++;
    if (row_n !== 4'b1111) begin bad++; $display("FAIL midreset_row_n: got %b want 1111", row_n); end
    reset = 1'b0;
    model_reset();
    bus_read(2'd1, d);
    total++;
    if (d !== 32'h0000_0200) begin bad++; $display("FAIL midreset_status: got %h want 00000200", d); end
    bus_read(2'd2, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL midreset_control: got %h want 0", d); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_overflow();
    test_disable();
    test_random();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
